gsu_bus_arbiter: RTL
====================

Name: gsu_bus_arbiter

Overview:
- Owns the external Game Pak ROM and RAM buses; arbitrates between SNES passthrough and GSU-initiated accesses.
- Ownership of each bus is selected by SCMR flags (ron for ROM, ran for RAM).
- GSU accesses run through a per-bus wait-state FSM with a req/ack handshake; SNES accesses pass through combinationally.
- Sits between the GSU core/cache fill logic and the cartridge pins, replacing the fixed inline ROM/RAM muxing in the top level.

Parameters:
ROM_AW, 21, ROM address width
RAM_AW, 17, RAM address width
ROM_WAIT, 3, extra cycles a GSU ROM access holds the bus before data capture (0..15)
RAM_WAIT, 2, extra cycles a GSU RAM access holds the bus before data capture/write end (0..15)

Ports:
clkin  in  1  system clock
RESET  in  1  synchronous active-high reset
ron  in  1  GSU owns ROM bus
ran  in  1  GSU owns RAM bus
snes_rom_rd  in  1  SNES ROM read (decoded is_rom & RD)
snes_rom_addr  in  ROM_AW  SNES-mapped ROM address
snes_ram_rd  in  1  SNES RAM read
snes_ram_wr  in  1  SNES RAM write
snes_ram_addr  in  RAM_AW  SNES-mapped RAM address
snes_wdata  in  8  SNES write data
gsu_rom_req  in  1  GSU ROM read request (level)
gsu_rom_addr  in  ROM_AW  GSU ROM address
gsu_rom_ack  out  1  one-cycle pulse, gsu_rom_rdata valid
gsu_rom_rdata  out  8  captured ROM byte
gsu_ram_req  in  1  GSU RAM request (level)
gsu_ram_we  in  1  1=write, 0=read
gsu_ram_addr  in  RAM_AW  GSU RAM address
gsu_ram_wdata  in  8  GSU write data
gsu_ram_ack  out  1  one-cycle completion pulse
gsu_ram_rdata  out  8  captured RAM byte
rom_addr  out  ROM_AW  ROM pin address
rom_data  in  8  ROM pin data
ROM_CE  out  1  ROM chip enable, active low
ram_addr  out  RAM_AW  RAM pin address
ram_din  in  8  RAM pin data in
ram_dout  out  8  RAM pin data out
ram_doe  out  1  drive ram_dout onto pins
RAM_OE  out  1  active low
RAM_WE  out  1  active low
wait_cnt  out  16  GSU stall counter (GSU_BUS_STATS_EN only)

Behaviour:
- Reset: both FSMs IDLE; acks 0; rdata 0; ROM_CE, RAM_OE, RAM_WE = 1; ram_doe 0; addresses 0.
- Bus owner is not GSU (ron/ran=0): pins follow SNES combinationally. ROM_CE = ~snes_rom_rd. RAM_OE = ~snes_ram_rd. RAM_WE = ~snes_ram_wr. ram_doe = snes_ram_wr, with ram_dout = snes_wdata.
- Bus owned by GSU: SNES strobes ignored and strobes idle high unless the FSM is active.
- FSM states per bus: IDLE, ACCESS, DONE.
- IDLE -> ACCESS: req=1 and owner=GSU. Latch addr/we/wdata; counter := WAIT.
- ACCESS: strobe low; ROM_CE low, or RAM_OE low (read), or RAM_WE low with ram_doe=1 (write). Pins driven from the latched address.
  - Decrement counter each cycle.
  - At counter==0: capture pin data into rdata (reads); go to DONE.
  - Total ACCESS length is WAIT+1 cycles.
- DONE: strobes high, ack=1 for exactly this cycle, -> IDLE.
- Request to ack latency: WAIT+3 cycles from req sampled high.
- The requester holds req until ack. A req still high in the cycle after ack starts a new access (back-to-back allowed).
- Ownership lost in ACCESS (ron/ran falls): abort to IDLE the same cycle. Strobes release immediately, no ack, rdata unchanged. The pending req restarts from the beginning when ownership returns.
- ROM and RAM FSMs are independent and may be active simultaneously.
- RESET mid-access: strobes high next cycle, no ack.
- Width rules: rdata 8-bit, no sign handling. WAIT counter is 4-bit; a parameter >15 is a synthesis error.

Optional Feature:
GSU_BUS_STATS_EN
- With the macro: wait_cnt counts cycles where any gsu_*_req=1 and the corresponding ack=0. Saturates at 16'hFFFF; cleared by RESET.
- Without the macro: wait_cnt port absent and no counter logic is generated.

Decomposition:
- Package gsu_bus_pkg holds the FSM state enum (IDLE/ACCESS/DONE) and the default wait constants.
- Sub-module gsu_bus_port is natural: one FSM plus latches, parametrised by AW and WAIT. It is instantiated twice; the ROM instance has its write path tied off.

Test Plan:
1. ron=0, snes_rom_rd=1, snes_rom_addr=21'h012345 -> rom_addr=21'h012345 and ROM_CE=0 combinationally; gsu_rom_req ignored, no ack.
2. ron=1, ROM_WAIT=3, gsu_rom_req at addr 21'h1F0000, rom_data=8'hA5 -> ROM_CE low for 4 cycles; gsu_rom_ack pulses exactly once 6 cycles after req; gsu_rom_rdata=8'hA5.
3. ran=1, RAM_WAIT=2, write 8'h3C to 17'h00100 then read it back -> RAM_WE low 3 cycles with ram_doe=1 and ram_dout=8'h3C; the read returns 8'h3C; two ack pulses in total.
4. ran falls at cycle 2 of a RAM read -> RAM_OE high the next cycle, no ack. ran reasserts -> the access restarts and acks after a full RAM_WAIT+3 cycles.
5. ROM and RAM requests issued the same cycle with ron=ran=1 -> both complete independently; acks at +6 and +5 cycles respectively.
6. RESET asserted mid-ROM access -> ROM_CE=1 and ack=0 next cycle; with GSU_BUS_STATS_EN, wait_cnt=0.

Source files
------------

// File: rtl/gsu_bus_pkg.sv
// Shared types and defaults for the GSU cartridge bus arbiter.
package gsu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } port_state_e;

  localparam int DEF_ROM_WAIT = 3;
  localparam int DEF_RAM_WAIT = 2;

endpackage

// File: rtl/gsu_bus_port.sv
// One GSU-side bus port: req/ack wait-state FSM with latched address/data.
// Strobes are registered; the top gates them with bus ownership.
module gsu_bus_port
  import gsu_bus_pkg::*;
#(
  parameter int AW   = 8,
  parameter int WAIT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          own,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  input  logic [7:0]    pin_data,
  output logic          ack,
  output logic [7:0]    rdata,
  output logic [AW-1:0] acc_addr,
  output logic [7:0]    acc_wdata,
  output logic          acc_rd,
  output logic          acc_wr
);

  if (WAIT < 0 || WAIT > 15) begin : g_wait_range
    $error("gsu_bus_port: WAIT must be within 0..15");
  end

  port_state_e state;
  logic [3:0]  cnt;
  logic        pend;

  // pend is req qualified by ownership one cycle late; it is dropped in DONE
  // so a requester that releases req right after ack never retriggers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= 1'b0;
      ack       <= 1'b0;
      rdata     <= '0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      acc_rd    <= 1'b0;
      acc_wr    <= 1'b0;
    end else begin
      ack  <= 1'b0;
      pend <= req & own & (state != DONE);
      case (state)
        IDLE: begin
          if (pend && own) begin
            state     <= ACCESS;
            cnt       <= 4'(WAIT);
            acc_addr  <= addr;
            acc_wdata <= wdata;
            acc_rd    <= ~we;
            acc_wr    <= we;
          end
        end
        ACCESS: begin
          if (!own) begin
            state  <= IDLE;
            acc_rd <= 1'b0;
            acc_wr <= 1'b0;
          end else if (cnt == 4'd0) begin
            if (acc_rd) rdata <= pin_data;
            state  <= DONE;
            ack    <= 1'b1;
            acc_rd <= 1'b0;
            acc_wr <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/gsu_bus_arbiter.sv
// Game Pak ROM/RAM bus arbiter: SNES passthrough vs GSU wait-state accesses.
// Define GSU_BUS_STATS_EN to add the saturating wait_cnt stall counter.
module gsu_bus_arbiter
  import gsu_bus_pkg::*;
#(
  parameter int ROM_AW   = 21,
  parameter int RAM_AW   = 17,
  parameter int ROM_WAIT = DEF_ROM_WAIT,
  parameter int RAM_WAIT = DEF_RAM_WAIT
) (
  input  logic              clkin,
  input  logic              RESET,
  input  logic              ron,
  input  logic              ran,
  input  logic              snes_rom_rd,
  input  logic [ROM_AW-1:0] snes_rom_addr,
  input  logic              snes_ram_rd,
  input  logic              snes_ram_wr,
  input  logic [RAM_AW-1:0] snes_ram_addr,
  input  logic [7:0]        snes_wdata,
  input  logic              gsu_rom_req,
  input  logic [ROM_AW-1:0] gsu_rom_addr,
  output logic              gsu_rom_ack,
  output logic [7:0]        gsu_rom_rdata,
  input  logic              gsu_ram_req,
  input  logic              gsu_ram_we,
  input  logic [RAM_AW-1:0] gsu_ram_addr,
  input  logic [7:0]        gsu_ram_wdata,
  output logic              gsu_ram_ack,
  output logic [7:0]        gsu_ram_rdata,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              ROM_CE,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic              ram_doe,
  output logic              RAM_OE,
  output logic              RAM_WE
`ifdef GSU_BUS_STATS_EN
  ,
  output logic [15:0]       wait_cnt
`endif
);

  logic [ROM_AW-1:0] rom_acc_addr;
  logic [RAM_AW-1:0] ram_acc_addr;
  logic [7:0]        ram_acc_wdata, rom_wdata_unused;
  logic              rom_rd, rom_wr, ram_rd, ram_wr;

  gsu_bus_port #(.AW(ROM_AW), .WAIT(ROM_WAIT)) u_rom (
    .clk(clkin), .rst(RESET), .own(ron), .req(gsu_rom_req), .we(1'b0),
    .addr(gsu_rom_addr), .wdata(8'h00), .pin_data(rom_data),
    .ack(gsu_rom_ack), .rdata(gsu_rom_rdata), .acc_addr(rom_acc_addr),
    .acc_wdata(rom_wdata_unused), .acc_rd(rom_rd), .acc_wr(rom_wr)
  );

  gsu_bus_port #(.AW(RAM_AW), .WAIT(RAM_WAIT)) u_ram (
    .clk(clkin), .rst(RESET), .own(ran), .req(gsu_ram_req), .we(gsu_ram_we),
    .addr(gsu_ram_addr), .wdata(gsu_ram_wdata), .pin_data(ram_din),
    .ack(gsu_ram_ack), .rdata(gsu_ram_rdata), .acc_addr(ram_acc_addr),
    .acc_wdata(ram_acc_wdata), .acc_rd(ram_rd), .acc_wr(ram_wr)
  );

  // Ownership gates the pins combinationally, so losing it releases strobes at once.
  always_comb begin
    rom_addr = ron ? rom_acc_addr  : snes_rom_addr;
    ROM_CE   = ron ? ~(rom_rd | rom_wr) : ~snes_rom_rd;
    ram_addr = ran ? ram_acc_addr  : snes_ram_addr;
    RAM_OE   = ran ? ~ram_rd        : ~snes_ram_rd;
    RAM_WE   = ran ? ~ram_wr        : ~snes_ram_wr;
    ram_doe  = ran ? ram_wr         : snes_ram_wr;
    ram_dout = ran ? ram_acc_wdata  : snes_wdata;
  end

`ifdef GSU_BUS_STATS_EN
  logic stall;
  assign stall = (gsu_rom_req & ~gsu_rom_ack) | (gsu_ram_req & ~gsu_ram_ack);

  always_ff @(posedge clkin) begin
    if (RESET)                            wait_cnt <= '0;
    else if (stall && wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
  end
`endif

endmodule
